// File: rtl/pla_ptp_sched_pkg.sv
// Shared types, XGMII constants and the round-robin pick helper
// for the PTP port scheduler.
package pla_ptp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_PASS  = 3'd2,
    S_FLUSH = 3'd3,
    S_IPG   = 3'd4
  } state_t;

  localparam logic [31:0] C_XGMII_IDLE_WORD  = 32'h07070707;
  localparam logic [31:0] C_XGMII_START_WORD = 32'hfb555555;
  localparam logic [31:0] C_XGMII_ABORT_WORD = 32'hFD070707;
  localparam logic [3:0]  C_TXC_IDLE         = 4'hf;
  localparam logic [3:0]  C_TXC_START        = 4'h8;

  // First requester strictly after 'last', wrapping at n-1.
  // Returns 'last' when nothing requests.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] req,
    input logic [2:0] last,
    input int         n
  );
    logic [2:0] pick;
    logic       found;
    int         j;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!found && i <= n) begin
        j = (int'(last) + i) % n;
        if (req[j[2:0]]) begin
          found = 1'b1;
          pick  = j[2:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pla_ptp_sched_rr_arb.sv
// Combinational round-robin arbiter for the PTP scheduler.
// Ports: i_req requests, i_last last grant, o_valid any request,
//        o_idx winner; i_hint class mask with PLA_PTP_SCHED_PRIO_EN.
module pla_ptp_sched_rr_arb
  import pla_ptp_sched_pkg::*;
#(
  parameter int C_PORT_NUM = 4
) (
  input  logic [C_PORT_NUM-1:0] i_req,
`ifdef PLA_PTP_SCHED_PRIO_EN
  input  logic [C_PORT_NUM-1:0] i_hint,
`endif
  input  logic [2:0]            i_last,
  output logic                  o_valid,
  output logic [2:0]            o_idx
);

  logic [7:0] w_req8;

  always_comb begin
    w_req8 = '0;
    w_req8[C_PORT_NUM-1:0] = i_req;
`ifdef PLA_PTP_SCHED_PRIO_EN
    // hinted requesters form their own class and shadow the rest
    if (|(i_req & i_hint)) begin
      w_req8[C_PORT_NUM-1:0] = i_req & i_hint;
    end
`endif
  end

  assign o_valid = |i_req;
  assign o_idx   = rr_pick(w_req8, i_last, C_PORT_NUM);

endmodule

// File: rtl/pla_forward_ptp_port_sched_32bit.sv
// Frame-granular round-robin scheduler sharing one 32-bit XGMII PTP path
// between C_PORT_NUM show-ahead frame FIFOs, with idle gap and truncation.
// Ports: I_sys_312m5_clk/I_sys_rst clock and async high reset;
//   I_port_req/_xgmii_d/_xgmii_txc/_crc_err FIFO heads; O_port_rd pops;
//   O_xgmii_d/_txc/_crc_err registered output; O_grant_port word owner;
//   O_statistic_pulse toggles (0 sent, 1 abort, 2 misaligned flush).
// Option: PLA_PTP_SCHED_PRIO_EN adds I_port_ptp_hint class priority.
module pla_forward_ptp_port_sched_32bit
  import pla_ptp_sched_pkg::*;
#(
  parameter int          C_PORT_NUM  = 4,
  parameter int          C_IPG_WORDS = 3,
  parameter logic [15:0] C_MAX_WORDS = 16'd2500
) (
  input  logic                      I_sys_312m5_clk,
  input  logic                      I_sys_rst,
  input  logic [C_PORT_NUM-1:0]     I_port_req,
  input  logic [32*C_PORT_NUM-1:0]  I_port_xgmii_d,
  input  logic [4*C_PORT_NUM-1:0]   I_port_xgmii_txc,
  input  logic [C_PORT_NUM-1:0]     I_port_crc_err,
`ifdef PLA_PTP_SCHED_PRIO_EN
  input  logic [C_PORT_NUM-1:0]     I_port_ptp_hint,
`endif
  output logic [C_PORT_NUM-1:0]     O_port_rd,
  output logic [31:0]               O_xgmii_d,
  output logic [3:0]                O_xgmii_txc,
  output logic                      O_xgmii_crc_err,
  output logic [2:0]                O_grant_port,
  output logic [2:0]                O_statistic_pulse
);

  localparam logic [7:0] C_IPG_LAST  = 8'(C_IPG_WORDS - 1);
  localparam logic [2:0] C_LAST_INIT = 3'(C_PORT_NUM - 1);

  state_t      r_state;
  logic [2:0]  r_grant;
  logic [2:0]  r_last;
  logic [15:0] r_wcnt;
  logic [7:0]  r_ipg_cnt;
  logic [31:0] r_d;
  logic [3:0]  r_txc;
  logic        r_crc;
  logic [2:0]  r_gp;
  logic [2:0]  r_stat;

  state_t      w_state_nxt;
  logic [2:0]  w_grant_nxt;
  logic [2:0]  w_last_nxt;
  logic [15:0] w_wcnt_nxt;
  logic [7:0]  w_ipg_nxt;
  logic [31:0] w_d_nxt;
  logic [3:0]  w_txc_nxt;
  logic        w_crc_nxt;
  logic [2:0]  w_gp_nxt;
  logic [2:0]  w_stat_nxt;

  logic        w_head_req;
  logic [31:0] w_head_d;
  logic [3:0]  w_head_txc;
  logic        w_head_crc;
  logic        w_pop;
  logic        w_arb_valid;
  logic [2:0]  w_arb_idx;

  pla_ptp_sched_rr_arb #(
    .C_PORT_NUM (C_PORT_NUM)
  ) u_arb (
    .i_req   (I_port_req),
`ifdef PLA_PTP_SCHED_PRIO_EN
    .i_hint  (I_port_ptp_hint),
`endif
    .i_last  (r_last),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  // head of the granted FIFO
  always_comb begin
    w_head_req = 1'b0;
    w_head_d   = '0;
    w_head_txc = '0;
    w_head_crc = 1'b0;
    for (int i = 0; i < C_PORT_NUM; i++) begin
      if (r_grant == 3'(i)) begin
        w_head_req = I_port_req[i];
        w_head_d   = I_port_xgmii_d[i*32 +: 32];
        w_head_txc = I_port_xgmii_txc[i*4 +: 4];
        w_head_crc = I_port_crc_err[i];
      end
    end
  end

  assign w_pop = ((r_state == S_PASS) || (r_state == S_FLUSH))
               && w_head_req;

  always_comb begin
    O_port_rd = '0;
    for (int i = 0; i < C_PORT_NUM; i++) begin
      O_port_rd[i] = w_pop && (r_grant == 3'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_wcnt_nxt  = r_wcnt;
    w_ipg_nxt   = r_ipg_cnt;
    w_d_nxt     = C_XGMII_IDLE_WORD;
    w_txc_nxt   = C_TXC_IDLE;
    w_crc_nxt   = 1'b0;
    w_gp_nxt    = r_gp;
    w_stat_nxt  = r_stat;
    unique case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_grant_nxt = w_arb_idx;
          w_last_nxt  = w_arb_idx;
          w_wcnt_nxt  = '0;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_head_req) begin
          if (w_head_d == C_XGMII_START_WORD
              && w_head_txc == C_TXC_START) begin
            w_state_nxt = S_PASS;
          end else begin
            w_stat_nxt[2] = ~r_stat[2];
            w_state_nxt   = S_FLUSH;
          end
        end
      end
      S_PASS: begin
        if (!w_head_req || r_wcnt >= C_MAX_WORDS) begin
          w_d_nxt       = C_XGMII_ABORT_WORD;
          w_crc_nxt     = 1'b1;
          w_gp_nxt      = r_grant;
          w_stat_nxt[1] = ~r_stat[1];
          w_state_nxt   = S_FLUSH;
          w_ipg_nxt     = '0;
          // an over-long frame still pops here; if that word closes
          // the frame there is nothing left to flush
          if (w_head_req && w_head_txc != 4'h0) begin
            w_state_nxt = S_IPG;
          end
        end else begin
          w_d_nxt    = w_head_d;
          w_txc_nxt  = w_head_txc;
          w_crc_nxt  = w_head_crc;
          w_gp_nxt   = r_grant;
          w_wcnt_nxt = r_wcnt + 16'd1;
          // the start word was already validated, so any later
          // control lane marks the terminate word
          if (w_head_txc != 4'h0 && r_wcnt != 16'd0) begin
            w_stat_nxt[0] = ~r_stat[0];
            w_ipg_nxt     = '0;
            w_state_nxt   = S_IPG;
          end
        end
      end
      S_FLUSH: begin
        if (w_head_req && w_head_txc != 4'h0) begin
          w_ipg_nxt   = '0;
          w_state_nxt = S_IPG;
        end
      end
      S_IPG: begin
        if (r_ipg_cnt >= C_IPG_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ipg_nxt = r_ipg_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_sys_312m5_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_last    <= C_LAST_INIT;
      r_wcnt    <= '0;
      r_ipg_cnt <= '0;
      r_d       <= C_XGMII_IDLE_WORD;
      r_txc     <= C_TXC_IDLE;
      r_crc     <= 1'b0;
      r_gp      <= '0;
      r_stat    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_ipg_cnt <= w_ipg_nxt;
      r_d       <= w_d_nxt;
      r_txc     <= w_txc_nxt;
      r_crc     <= w_crc_nxt;
      r_gp      <= w_gp_nxt;
      r_stat    <= w_stat_nxt;
    end
  end

  assign O_xgmii_d         = r_d;
  assign O_xgmii_txc       = r_txc;
  assign O_xgmii_crc_err   = r_crc;
  assign O_grant_port      = r_gp;
  assign O_statistic_pulse = r_stat;

endmodule
